// File: rtl/rolled_copy_pkg.sv
// Shared types and sizing helpers for the rolled word copier.
package rolled_copy_pkg;

  localparam int unsigned DEFAULT_W     = 256;
  localparam int unsigned DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned num_chunks(input int unsigned w, input int unsigned chunk);
    return (chunk == 0) ? 0 : w / chunk;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rolled_copy_if.sv
// Source/sink handshake bundle for the rolled word copier.
interface rolled_copy_if
  import rolled_copy_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] s;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, s, out_valid, busy
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, s, out_valid, busy
  );

endinterface

// File: rtl/rolled_copy_chunk_counter.sv
// Chunk index for the rolled copy: clear, step, wrap at the last chunk.
module chunk_counter #(
  parameter int unsigned NUM = 32,
  parameter int unsigned IW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [IW-1:0] idx_o,
  output logic          tc_c
);

  localparam logic [IW-1:0] LAST = IW'(NUM - 1);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;

  assign tc_c  = (idx_q == LAST);
  assign idx_o = idx_q;

  // Wrap on terminal count so the index never leaves 0..NUM-1.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = tc_c ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/rolled_copy.sv
// Rolled bit copy: captures a word, then moves one CHUNK-bit slice per cycle into s.
module rolled_copy
  import rolled_copy_pkg::*;
#(
  parameter int unsigned W     = DEFAULT_W,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input logic          clk,
  input logic          rst,
  rolled_copy_if.slave bus
);

  localparam int unsigned N  = num_chunks(W, CHUNK);
  localparam int unsigned IW = idx_width(N);

  if (CHUNK == 0 || W == 0 || (W % CHUNK) != 0) begin : g_bad_width
    $error("rolled_copy: W must be a positive multiple of CHUNK");
  end

  state_e state_q;
  state_e state_d;

  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;

  logic [N-1:0][CHUNK-1:0] shadow_q;
  logic [N-1:0][CHUNK-1:0] s_q;

  logic          accept_c;
  logic          copy_c;
  logic          tc_c;
  logic [IW-1:0] idx;

  assign accept_c = (state_q == IDLE) && bus.in_valid;
  assign copy_c   = (state_q == COPY);

  chunk_counter #(
    .NUM (N),
    .IW  (IW)
  ) u_chunk_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept_c),
    .en_i  (copy_c),
    .idx_o (idx),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = COPY;
      COPY:    if (tc_c)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Flags are decoded from the next state so they line up with state_q.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      COPY:    busy_d      = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: in_ready_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Unwritten slices of s keep their old contents until their turn comes.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      s_q      <= '0;
    end else begin
      if (accept_c) begin
        shadow_q <= bus.a;
      end
      if (copy_c) begin
        s_q[idx] <= shadow_q[idx];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.s         = s_q;

endmodule

// File: tb/tb_rolled_copy.sv
// Scoreboard bench for rolled_copy at W=256 and W=8.
module tb_rolled_copy;
  import rolled_copy_pkg::*;

  localparam int unsigned W = 256;
  localparam int unsigned N = W / 8;

  typedef struct {
    logic [W-1:0] word;
    int unsigned  cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  exp_t        sb_q[$];
  int unsigned deliv_q[$];

  rolled_copy_if #(.W(W)) bus ();
  rolled_copy_if #(.W(8)) bus8 ();

  rolled_copy #(.W(W), .CHUNK(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rolled_copy #(.W(8), .CHUNK(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word, wait for in_ready, and record it once the accepting edge passes.
  task automatic send(input logic [W-1:0] w, input bit keep_valid);
    bus.in_valid = 1'b1;
    bus.a        = w;
    for (int i = 0; i < 100 && bus.in_ready !== 1'b1; i++) tick();
    chk("send_ready", W'(bus.in_ready), W'(1));
    @(posedge clk);
    #1;
    sb_q.push_back('{w, cyc});
    bus.in_valid = keep_valid;
  endtask

  task automatic wait_out(output int unsigned ready_hi);
    ready_hi = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid === 1'b1) break;
      if (bus.in_ready !== 1'b0) ready_hi++;
      tick();
    end
    chk("wait_out_timeout", W'(bus.out_valid), W'(1));
  endtask

  // Pop and compare on each rising out_valid.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_out", W'(bus.out_valid), W'(0));
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", bus.s, e.word);
          chk("sb_latency", W'(cyc - e.cyc), W'(N));
          deliv_q.push_back(cyc);
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  initial begin
    logic [W-1:0] p, q, r, aa, ff;
    int unsigned  hi, bad;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_s", bus.s, '0);
    rst = 1'b0;
    tick();

    // Plain copy with the sink always ready.
    p = {4{64'h0123_4567_89AB_CDEF}};
    send(p, 1'b0);
    wait_out(hi);
    chk("t1_in_ready_copy", W'(hi), W'(0));
    chk("t1_s", bus.s, p);
    tick();
    chk("t1_idle_ready", W'(bus.in_ready), W'(1));
    chk("t1_ov_drop", W'(bus.out_valid), W'(0));
    chk("t1_sb_drained", W'(sb_q.size()), W'(0));

    // Source changes after acceptance; sink stalls for 10 cycles in DONE.
    bus.out_ready = 1'b0;
    q = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    ff = '1;
    send(q, 1'b0);
    tick();
    bus.a = ff;
    wait_out(hi);
    chk("t2_in_ready_copy", W'(hi), W'(0));
    chk("t2_s_orig", bus.s, q);
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.s !== q || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    chk("t3_hold_stable", W'(bad), W'(0));
    bus.out_ready = 1'b1;
    tick();
    chk("t3_idle_ready", W'(bus.in_ready), W'(1));
    chk("t3_ov_drop", W'(bus.out_valid), W'(0));
    chk("t3_busy", W'(bus.busy), W'(0));

    // Reset in the middle of a copy: partial slices, then a clean abort.
    r = ~q ^ {8{32'h5A5A_C3C3}};
    send(r, 1'b0);
    repeat (15) tick();
    chk("t4_partial_s", bus.s, {q[W-1:120], r[119:0]});
    chk("t4_busy", W'(bus.busy), W'(1));
    rst = 1'b1;
    tick();
    chk("t4_rst_s", bus.s, '0);
    chk("t4_rst_ov", W'(bus.out_valid), W'(0));
    chk("t4_rst_ready", W'(bus.in_ready), W'(1));
    chk("t4_rst_busy", W'(bus.busy), W'(0));
    sb_q.delete();
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    chk("t4_no_out_valid", W'(bad), W'(0));

    // Back-to-back words with in_valid held high.
    deliv_q.delete();
    aa = {32{8'hAA}};
    send(aa, 1'b1);
    send({32{8'h55}}, 1'b0);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    chk("t5_sb_drained", W'(sb_q.size()), W'(0));
    chk("t5_deliveries", W'(deliv_q.size()), W'(2));
    if (deliv_q.size() == 2)
      chk("t5_spacing", W'(deliv_q[1] - deliv_q[0]), W'(N + 2));
    tick();

    // W == CHUNK: a single copy cycle.
    bus8.in_valid = 1'b1;
    bus8.a        = 8'hA5;
    chk("t6_ready", W'(bus8.in_ready), W'(1));
    tick();
    bus8.in_valid = 1'b0;
    chk("t6_busy", W'(bus8.busy), W'(1));
    chk("t6_ov_early", W'(bus8.out_valid), W'(0));
    tick();
    chk("t6_ov", W'(bus8.out_valid), W'(1));
    chk("t6_s", W'(bus8.s), W'(8'hA5));
    tick();
    chk("t6_idle_ready", W'(bus8.in_ready), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rolled_copy.md
ROLLED_COPY -- requirements
Module: rolled_copy

Interface
REQ-001 The block SHALL have parameter W, default 256, meaning the copied word width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning the bits copied per cycle.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  source offers word a.
REQ-006 The block SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 The block SHALL have port a  input  W  source word, sampled only on acceptance.
REQ-008 The block SHALL have port s  output  W  registered copy of the accepted word.
REQ-009 The block SHALL have port out_valid  output  1  s holds the complete copy.
REQ-010 The block SHALL have port out_ready  input  1  sink consumes s.
REQ-011 The block SHALL have port busy  output  1  a copy is in progress (state COPY).

Function
REQ-012 The block SHALL be the rolled, time-multiplexed counterpart of the fully unrolled bit copy: one CHUNK-bit slice per cycle.
REQ-013 The state machine SHALL have exactly the states IDLE, COPY and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in COPY and DONE, in_ready SHALL be 0.
REQ-015 On in_valid && in_ready, the block SHALL capture a into an internal W-bit shadow register, clear the chunk index to 0 and enter COPY.
REQ-016 In each COPY cycle, the block SHALL write s[idx*CHUNK +: CHUNK] from the same shadow slice, then increment idx.
REQ-017 Slices of s not yet written for the current word SHALL hold their previous values.
REQ-018 When idx equals NUM_CHUNKS-1, after writing that slice the block SHALL enter DONE with out_valid=1 on the next cycle.
REQ-019 Latency SHALL be NUM_CHUNKS cycles from the acceptance edge to the first cycle with out_valid=1 (W=256, CHUNK=8: 32 cycles).
REQ-020 In DONE, out_valid and s SHALL hold stable until out_ready=1; on that edge the block SHALL return to IDLE.
REQ-021 The DONE-to-IDLE handoff SHALL cost one cycle: no acceptance occurs in the same cycle as out_ready; back-to-back throughput is one word per NUM_CHUNKS+2 cycles.
REQ-022 Changes on a after acceptance SHALL NOT affect s.
REQ-023 idx width SHALL be max(1, clog2(NUM_CHUNKS)); idx SHALL never exceed NUM_CHUNKS-1.
REQ-024 When W==CHUNK, COPY SHALL last exactly one cycle.
REQ-025 W SHALL be a positive multiple of CHUNK; otherwise elaboration SHALL fail.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, idx=0, s=0, shadow=0, out_valid=0, busy=0, in_ready=1 after the edge.
REQ-027 Reset asserted during COPY or DONE SHALL abort the word; no partial out_valid pulse SHALL follow.
REQ-028 Reset SHALL take priority over a simultaneous in_valid or out_ready.

Structure
REQ-029 The shared package SHALL hold the state enum (IDLE, COPY, DONE), the default CHUNK and the NUM_CHUNKS=W/CHUNK helper.
REQ-030 The chunk index SHALL be a sub-module chunk_counter (clear, enable, terminal-count output).
REQ-031 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-032 The bench SHALL cover: reset, then W=256, a=0x0123...CDEF repeated, out_ready=1 -> out_valid at cycle 32 after acceptance, s==a, in_ready=0 throughout.
REQ-033 The bench SHALL cover: a changed to all-ones one cycle after acceptance -> s still equals the originally captured value.
REQ-034 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> s and out_valid stable, in_ready=0; out_ready=1 -> IDLE on the next cycle.
REQ-035 The bench SHALL cover: rst pulsed at copy cycle 15 -> s=0, out_valid never asserts, in_ready=1 on the cycle after the reset edge.
REQ-036 The bench SHALL cover: W=8, a=0xA5 -> out_valid one cycle after acceptance, s=0xA5.
REQ-037 The bench SHALL cover: two back-to-back words 0xAA.., 0x55.. with in_valid held high -> both delivered in order, 34 cycles apart.
